lcd_spi_stream: RTL and testbench

//  Buffered write-only SPI link to a MIPI-DBI style LCD controller. Accepts {dc, byte}

---
 rtl/lcd_spi_stream.sv | 144 ++++++++++++++
 tb/tb_lcd_spi_stream.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_stream.sv
// Buffered write-only SPI link to a MIPI-DBI LCD: 16-deep {dc,byte} FIFO,
// mode-0 byte shifter, and a hold-off timer after power commands.
module lcd_spi_stream #(
    parameter int unsigned FREQ  = 25_000_000,
    parameter int unsigned DELAY = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dc,
    input  logic [7:0] in,
    input  logic       put,
    output logic       full,
    output logic       LCD_reset_n,
    output logic       LCD_clock,
    output logic       LCD_cs_n,
    output logic       LCD_dc,
    output logic       LCD_mosi,
    input  logic       LCD_miso
);
    localparam int unsigned TIMEOUT = DELAY * (FREQ / 1000);
    localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);

    typedef enum logic {IDLE, SHIFT} state_e;

    logic [8:0]    mem_q [16];
    logic [3:0]    wr_q;
    logic [3:0]    rd_q;
    logic [4:0]    cnt_q;
    logic [8:0]    head;
    logic          empty;
    logic          push;
    logic          pop;

    logic [TW-1:0] timer_q;
    logic          ready_n;
    logic          power_cmd;

    state_e        state_q;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    shreg_q;
    logic [7:0]    rx_unused_q;
    logic          sck_q;
    logic          cs_n_q;
    logic          dc_q;
    logic          mosi_q;

    assign full  = cnt_q == 5'd16;
    assign empty = cnt_q == 5'd0;
    assign head  = mem_q[rd_q];

    assign pop  = (state_q == IDLE) && !empty && !ready_n;
    assign push = put && (!full || pop);

    // A full FIFO still accepts a word in the same cycle a word leaves.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_q] <= {dc, in};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + 4'd1;
            end
            if (pop) begin
                rd_q <= rd_q + 4'd1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 5'd1;
                2'b01:   cnt_q <= cnt_q - 5'd1;
                default: ;
            endcase
        end
    end

    assign power_cmd = (head == 9'h001) || (head == 9'h010) || (head == 9'h011);
    assign ready_n   = timer_q != '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q <= '0;
        end else if (pop && power_cmd) begin
            timer_q <= TIMER_LOAD;
        end else if (ready_n) begin
            timer_q <= timer_q - TW'(1);
        end
    end

    // Even shift cycles hold SCK low with MOSI set up; odd cycles raise SCK.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_unused_q <= '0;
            sck_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            dc_q        <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        shreg_q   <= {head[6:0], 1'b0};
                        mosi_q    <= head[7];
                        dc_q      <= head[8];
                        cs_n_q    <= 1'b0;
                        sck_q     <= 1'b0;
                    end
                end
                SHIFT: begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        state_q <= IDLE;
                        cs_n_q  <= 1'b1;
                        sck_q   <= 1'b0;
                        mosi_q  <= 1'b0;
                    end else if (!bit_cnt_q[0]) begin
                        sck_q       <= 1'b1;
                        rx_unused_q <= {rx_unused_q[6:0], LCD_miso};
                    end else begin
                        sck_q   <= 1'b0;
                        mosi_q  <= shreg_q[7];
                        shreg_q <= {shreg_q[6:0], 1'b0};
                    end
                end
            endcase
        end
    end

    assign LCD_reset_n = ~reset;
    assign LCD_clock   = sck_q;
    assign LCD_cs_n    = cs_n_q;
    assign LCD_dc      = dc_q;
    assign LCD_mosi    = mosi_q;
endmodule

// File: tb/tb_lcd_spi_stream.sv
// Bench for lcd_spi_stream: timeline model of frames and FIFO plus
// directed scenarios with hand-computed frame contents and spacing.
module tb_lcd_spi_stream;
    localparam int TIMEOUT = 40;

    logic       clock = 1'b0;
    logic       reset;
    logic       dc_b;
    logic [7:0] in_b;
    logic       put;
    logic       full;
    logic       LCD_reset_n;
    logic       LCD_clock;
    logic       LCD_cs_n;
    logic       LCD_dc;
    logic       LCD_mosi;
    logic       LCD_miso;

    int checks = 0;
    int errors = 0;

    lcd_spi_stream #(.FREQ(1000), .DELAY(40)) dut (
        .clock(clock),
        .reset(reset),
        .dc(dc_b),
        .in(in_b),
        .put(put),
        .full(full),
        .LCD_reset_n(LCD_reset_n),
        .LCD_clock(LCD_clock),
        .LCD_cs_n(LCD_cs_n),
        .LCD_dc(LCD_dc),
        .LCD_mosi(LCD_mosi),
        .LCD_miso(LCD_miso)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Model: words queue; a frame popped in cycle p drives CS low in
    // cycles p+1..p+16; next pop no earlier than p+17, or p+TIMEOUT+1
    // after a power command.
    logic [8:0] mq[$];
    int         cyc = 0;
    int         p_last = -100;
    int         ready_at = 0;
    logic [7:0] f_byte = 8'h00;
    logic       f_dc = 1'b0;
    bit         armed = 0;

    always @(posedge clock) begin
        logic [8:0] w;
        if (reset) begin
            mq.delete();
            p_last   = -100;
            ready_at = 0;
            f_byte   = 8'h00;
            f_dc     = 1'b0;
            armed    = 1;
        end else begin
            if (cyc >= p_last + 17 && cyc >= ready_at && mq.size() > 0) begin
                w      = mq.pop_front();
                p_last = cyc;
                f_byte = w[7:0];
                f_dc   = w[8];
                if (w == 9'h001 || w == 9'h010 || w == 9'h011)
                    ready_at = cyc + TIMEOUT + 1;
            end
            if (put && mq.size() < 16)
                mq.push_back({dc_b, in_b});
        end
        cyc++;
    end

    always @(negedge clock) begin
        int k;
        logic e_cs, e_sck, e_mosi;
        if (armed) begin
            k = cyc - p_last - 1;
            if (k >= 0 && k < 16) begin
                e_cs   = 1'b0;
                e_sck  = k[0];
                e_mosi = f_byte[7 - k / 2];
            end else begin
                e_cs   = 1'b1;
                e_sck  = 1'b0;
                e_mosi = 1'b0;
            end
            chk("pins{cs,sck,mosi,dc,full,rstn}",
                {26'd0, LCD_cs_n, LCD_clock, LCD_mosi, LCD_dc, full, LCD_reset_n},
                {26'd0, e_cs, e_sck, e_mosi, f_dc, (mq.size() == 16), ~reset});
        end
    end

    // Frame decoder from the pins, used for literal expectations.
    logic [8:0] rxq[$];
    int         lenq[$];
    int         falls[$];
    bit         in_f = 0;
    logic [7:0] bits;
    logic       fdc;
    int         lowcnt;

    always @(negedge clock) begin
        if (reset) begin
            in_f = 0;
        end else if (armed) begin
            if (!LCD_cs_n) begin
                if (!in_f) begin
                    in_f   = 1;
                    bits   = 8'h00;
                    lowcnt = 0;
                    fdc    = LCD_dc;
                    falls.push_back(cyc);
                end
                lowcnt++;
                if (LCD_clock) bits = {bits[6:0], LCD_mosi};
            end else if (in_f) begin
                in_f = 0;
                rxq.push_back({fdc, bits});
                lenq.push_back(lowcnt);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        LCD_miso = ~LCD_miso;
    endtask

    task automatic put_word(input logic d, input logic [7:0] b);
        dc_b = d;
        in_b = b;
        put  = 1'b1;
        tick();
        put  = 1'b0;
    endtask

    initial begin
        int b;
        int nf;
        int nr;
        reset    = 1'b1;
        put      = 1'b0;
        dc_b     = 1'b0;
        in_b     = 8'h00;
        LCD_miso = 1'b0;
        tick();
        tick();
        chk("rst_cs_n", LCD_cs_n, 1);
        chk("rst_sck", LCD_clock, 0);
        chk("rst_mosi", LCD_mosi, 0);
        chk("rst_dc", LCD_dc, 0);
        chk("rst_full", full, 0);
        chk("rst_lcd_reset_n", LCD_reset_n, 0);
        reset = 1'b0;
        tick();
        chk("lcd_reset_n_rel", LCD_reset_n, 1);

        // Single command byte
        b = rxq.size();
        put_word(1'b0, 8'hA5);
        repeat (20) tick();
        chk("t1_frames", rxq.size() - b, 1);
        chk("t1_word", rxq[b], 9'h0A5);
        chk("t1_cs_len", lenq[b], 16);

        // Back-to-back frames
        b = rxq.size();
        put_word(1'b1, 8'h3C);
        put_word(1'b0, 8'h2A);
        put_word(1'b1, 8'hFF);
        repeat (60) tick();
        chk("t2_frames", rxq.size() - b, 3);
        chk("t2_w0", rxq[b], 9'h13C);
        chk("t2_w1", rxq[b+1], 9'h02A);
        chk("t2_w2", rxq[b+2], 9'h1FF);
        chk("t2_gap01", falls[b+1] - falls[b], 17);
        chk("t2_gap12", falls[b+2] - falls[b+1], 17);

        // Fill during SWRESET hold-off; 17th word dropped
        b = rxq.size();
        put_word(1'b0, 8'h01);
        repeat (3) tick();
        for (int i = 0; i < 17; i++) begin
            put_word(1'b1, 8'h40 + 8'(i));
            if (i == 14) chk("t3_not_full_15", full, 0);
            if (i == 15) chk("t3_full_16", full, 1);
        end
        chk("t3_full_17", full, 1);
        repeat (300) tick();
        chk("t3_frames", rxq.size() - b, 17);
        chk("t3_trigger", rxq[b], 9'h001);
        for (int i = 0; i < 16; i++)
            chk("t3_order", rxq[b+1+i], 9'h140 + 9'(i));
        chk("t3_empty_full", full, 0);

        // SLPOUT hold-off versus a data byte of the same value
        b = rxq.size();
        put_word(1'b0, 8'h11);
        repeat (3) tick();
        put_word(1'b0, 8'h29);
        repeat (80) tick();
        chk("t4_frames", rxq.size() - b, 2);
        chk("t4_w29", rxq[b+1], 9'h029);
        chk("t4_holdoff", (falls[b+1] - falls[b]) >= 40, 1);
        b = rxq.size();
        put_word(1'b1, 8'h11);
        put_word(1'b0, 8'h29);
        repeat (45) tick();
        chk("t4b_frames", rxq.size() - b, 2);
        chk("t4b_w11", rxq[b], 9'h111);
        chk("t4b_gap", falls[b+1] - falls[b], 17);

        // Reset in the middle of a frame with a full FIFO
        put_word(1'b0, 8'h10);
        repeat (20) tick();
        for (int i = 0; i < 16; i++)
            put_word(1'b1, 8'h80 + 8'(i));
        chk("t5_full", full, 1);
        repeat (8) tick();
        put_word(1'b1, 8'hEE);
        chk("t5_full_again", full, 1);
        chk("t5_mid_frame", LCD_cs_n, 0);
        reset = 1'b1;
        tick();
        chk("t5_cs_n", LCD_cs_n, 1);
        chk("t5_sck", LCD_clock, 0);
        chk("t5_full_clr", full, 0);
        chk("t5_lcd_reset_n", LCD_reset_n, 0);
        nf = falls.size();
        nr = rxq.size();
        reset = 1'b0;
        repeat (40) tick();
        chk("t5_no_new_fall", falls.size(), nf);
        chk("t5_no_new_frame", rxq.size(), nr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
